// File: rtl/cis_pkg.sv
// cis_pkg: shared widths, state encoding and helpers for the CIS line sequencer
package cis_pkg;
    localparam int PIX_W     = 12;
    localparam int PIX_CNT_W = 12;
    localparam int DUM_CNT_W = 7;
    localparam int LINE_W    = 16;
    localparam int OVF_W     = 8;
    localparam int TMR_W     = 16;

    typedef enum logic [2:0] {IDLE, SI, DUMMY, ACTIVE, TAIL} cis_state_t;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/cis_sclk_gen.sv
// cis_sclk_gen: free-running SCLK phase counter with registered clock and rise/fall event strobes
module cis_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sclk_o,
    output logic rise,
    output logic fall
);
    localparam int HALF = CLK_DIV / 2;
    localparam int PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          sclk_q, sclk_d;

    assign rise   = phase_q == '0;
    assign fall   = phase_q == PW'(HALF);
    assign sclk_o = sclk_q;

    // next phase wraps at CLK_DIV-1; sclk is registered from the next phase so it tracks phase_q
    always_comb begin
        phase_d = (phase_q == PW'(CLK_DIV - 1)) ? '0 : phase_q + 1'b1;
        sclk_d  = phase_d < PW'(HALF);
    end

    // phase and sclk registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            sclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end
endmodule

// File: rtl/cis_line_sequencer.sv
// cis_line_sequencer: CIS line FSM (SI, dummy skip, pixel capture, tail); CIS_TESTPAT_EN selects index test pattern
module cis_line_sequencer
    import cis_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int DUMMY_PIX   = 89,
    parameter int ACTIVE_PIX  = 2592,
    parameter int TAIL_CLKS   = 8,
    parameter int LINE_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trig,
    input  logic [PIX_W-1:0]  adc_data,
    output logic              sclk_o,
    output logic              si_o,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              busy,
    output logic [LINE_W-1:0] line_cnt,
    output logic [OVF_W-1:0]  trig_ovf
);
    if (CLK_DIV < 2 || CLK_DIV % 2 != 0) begin : g_bad_div
        $error("CLK_DIV must be even and >= 2");
    end
    if (ACTIVE_PIX < 1 || ACTIVE_PIX >= 4096) begin : g_bad_active
        $error("ACTIVE_PIX must be in 1..4095");
    end
    if (DUMMY_PIX < 0 || DUMMY_PIX >= 128) begin : g_bad_dummy
        $error("DUMMY_PIX must be in 0..127");
    end
    if (TAIL_CLKS < 0 || TAIL_CLKS > 128 || LINE_PERIOD < 0 || LINE_PERIOD > 65536) begin : g_bad_misc
        $error("TAIL_CLKS or LINE_PERIOD out of range");
    end

    logic                 rise, fall, start, timer_exp, ev;
    cis_state_t           state_q, state_d;
    logic                 si_q, si_d, busy_q, busy_d, pend_q, pend_d;
    logic                 pix_valid_q, pix_valid_d, pix_sol_q, pix_sol_d, pix_eol_q, pix_eol_d;
    logic [PIX_W-1:0]     pix_data_q, pix_data_d;
    logic [LINE_W-1:0]    line_cnt_q, line_cnt_d;
    logic [OVF_W-1:0]     trig_ovf_q, trig_ovf_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [DUM_CNT_W-1:0] dum_cnt_q, dum_cnt_d;

    cis_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk   (clk),
        .rst   (rst),
        .sclk_o(sclk_o),
        .rise  (rise),
        .fall  (fall)
    );

    assign si_o      = si_q;
    assign busy      = busy_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_sol   = pix_sol_q;
    assign pix_eol   = pix_eol_q;
    assign line_cnt  = line_cnt_q;
    assign trig_ovf  = trig_ovf_q;

    // trigger/timer arbitration and line FSM next-state; the dummy counter doubles as the tail counter
    always_comb begin
        timer_exp   = (LINE_PERIOD != 0) && fall && (tmr_q == TMR_W'(LINE_PERIOD - 1));
        start       = (state_q == IDLE) && fall && enable && (pend_q || timer_exp);
        ev          = trig || (timer_exp && !start);
        pend_d      = start ? trig : (pend_q || ev);
        trig_ovf_d  = (!start && ev && pend_q) ? sat_inc(trig_ovf_q) : trig_ovf_q;
        tmr_d       = (LINE_PERIOD == 0 || start || timer_exp) ? '0 : (fall ? tmr_q + 1'b1 : tmr_q);
        state_d     = state_q;
        dum_cnt_d   = dum_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        pix_data_d  = pix_data_q;
        line_cnt_d  = line_cnt_q;
        pix_valid_d = 1'b0;
        pix_sol_d   = 1'b0;
        pix_eol_d   = 1'b0;
        case (state_q)
            IDLE: state_d = start ? SI : IDLE;
            SI: if (fall) begin
                state_d   = (DUMMY_PIX == 0) ? ACTIVE : DUMMY;
                dum_cnt_d = '0;
                pix_cnt_d = '0;
            end
            DUMMY: begin
                if (rise) dum_cnt_d = dum_cnt_q + 1'b1;
                if (fall && dum_cnt_q == DUM_CNT_W'(DUMMY_PIX)) state_d = ACTIVE;
            end
            ACTIVE: if (fall) begin
                pix_valid_d = 1'b1;
`ifdef CIS_TESTPAT_EN
                pix_data_d  = PIX_W'(pix_cnt_q) ^ {line_cnt_q[3:0], 8'h00};
`else
                pix_data_d  = adc_data;
`endif
                pix_sol_d   = pix_cnt_q == '0;
                pix_eol_d   = pix_cnt_q == PIX_CNT_W'(ACTIVE_PIX - 1);
                pix_cnt_d   = pix_cnt_q + 1'b1;
                if (pix_eol_d) begin
                    state_d    = (TAIL_CLKS == 0) ? IDLE : TAIL;
                    line_cnt_d = line_cnt_q + 1'b1;
                    dum_cnt_d  = '0;
                end
            end
            TAIL: if (fall) begin
                dum_cnt_d = dum_cnt_q + 1'b1;
                if (dum_cnt_q == DUM_CNT_W'(TAIL_CLKS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        si_d   = state_d == SI;
        busy_d = state_d != IDLE;
    end

    // state, counters and registered outputs; reset aborts any line in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            si_q        <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_sol_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_data_q  <= '0;
            line_cnt_q  <= '0;
            trig_ovf_q  <= '0;
            tmr_q       <= '0;
            pix_cnt_q   <= '0;
            dum_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            si_q        <= si_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pix_valid_q <= pix_valid_d;
            pix_sol_q   <= pix_sol_d;
            pix_eol_q   <= pix_eol_d;
            pix_data_q  <= pix_data_d;
            line_cnt_q  <= line_cnt_d;
            trig_ovf_q  <= trig_ovf_d;
            tmr_q       <= tmr_d;
            pix_cnt_q   <= pix_cnt_d;
            dum_cnt_q   <= dum_cnt_d;
        end
    end
endmodule

// File: tb/tb_cis_line_sequencer.sv
// tb_cis_line_sequencer: randomized scoreboard bench with a line-level trigger model and a free-run timer instance
module tb_cis_line_sequencer;
    localparam int CLK_DIV    = 4;
    localparam int DUMMY_PIX  = 89;
    localparam int ACTIVE_PIX = 2592;
    localparam int TAIL_CLKS  = 8;
    localparam int LP2        = 3000;

    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1, enable = 1'b0, trig = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic sclk_o, si_o, pix_valid, pix_sol, pix_eol, busy;
    logic [11:0] pix_data;
    logic [15:0] line_cnt;
    logic [7:0]  trig_ovf;
    logic t_sclk, t_si, t_valid, t_sol, t_eol, t_busy;
    logic [11:0] t_data;
    logic [15:0] t_lines;
    logic [7:0]  t_ovf;

    always #10 clk = ~clk;

    cis_line_sequencer u_dut (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig), .adc_data(adc_data),
        .sclk_o(sclk_o), .si_o(si_o), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .busy(busy), .line_cnt(line_cnt), .trig_ovf(trig_ovf)
    );

    cis_line_sequencer #(.LINE_PERIOD(LP2)) u_tmr (
        .clk(clk), .rst(rst2), .enable(1'b1), .trig(1'b0), .adc_data(12'd0),
        .sclk_o(t_sclk), .si_o(t_si), .pix_data(t_data), .pix_valid(t_valid),
        .pix_sol(t_sol), .pix_eol(t_eol), .busy(t_busy), .line_cnt(t_lines), .trig_ovf(t_ovf)
    );

    typedef struct {
        logic [11:0] d;
        logic        sol;
        logic        eol;
    } pix_t;

    pix_t sb[$];
    int n_cmp = 0, n_bad = 0;
    int pix_seen = 0, eol_seen = 0, si_rises = 0, si_w = 0, t_rises = 0;
    logic si_prev = 1'b0, t_si_prev = 1'b0, sclk_prev = 1'b0;
    longint cyc = 0, t_last = -1;

    bit m_busy = 0, m_pend = 0, m_en = 0;
    int m_lines = 0, m_ovf = 0, m_pushed = 0, m_starts = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // expected line: sensor counts rises from SI, so pixel n carries rise number DUMMY_PIX+1+n
    function automatic void push_line();
        pix_t e;
        for (int n = 0; n < ACTIVE_PIX; n++) begin
`ifdef CIS_TESTPAT_EN
            e.d = 12'(n) ^ {4'(m_pushed), 8'h00};
`else
            e.d = 12'(DUMMY_PIX + 1 + n);
`endif
            e.sol = (n == 0);
            e.eol = (n == ACTIVE_PIX - 1);
            sb.push_back(e);
        end
        m_pushed++;
    endfunction

    task automatic issue_trig();
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
        if (!m_busy && !m_pend && m_en) begin
            m_busy = 1; m_starts++; push_line();
        end else if (m_pend) begin
            m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
        end else begin
            m_pend = 1; push_line();
        end
    endtask

    task automatic wait_lines(input int n);
        int tgt = eol_seen + n;
        int i = 0;
        while (eol_seen < tgt && i < n * 12000 + 4000) begin
            @(negedge clk); i++;
        end
        chk("lines_done", eol_seen, tgt);
        repeat (n) begin
            m_lines++;
            if (m_pend && m_en) begin
                m_pend = 0; m_starts++;
            end else m_busy = 0;
        end
    endtask

    task automatic wait_pix(input int k);
        int tgt = pix_seen + k;
        int i = 0;
        while (pix_seen < tgt && i < k * CLK_DIV + 2000) begin
            @(negedge clk); i++;
        end
        chk("pix_reached", 32'(pix_seen >= tgt), 1);
    endtask

    task automatic check_idle(input string tag);
        repeat ((TAIL_CLKS + 4) * CLK_DIV) @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_line_cnt"}, line_cnt, m_lines);
        chk({tag, "_trig_ovf"}, trig_ovf, m_ovf);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_si_count"}, si_rises, m_starts);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sclk"}, sclk_o, 0);
        chk({tag, "_si"}, si_o, 0);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_sol"}, pix_sol, 0);
        chk({tag, "_eol"}, pix_eol, 0);
        chk({tag, "_data"}, pix_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_line_cnt"}, line_cnt, 0);
        chk({tag, "_trig_ovf"}, trig_ovf, 0);
    endtask

    always @(posedge clk) cyc++;

    // sensor: adc_data = SCLK rises since SI rose (rise under SI is edge 0)
    always @(negedge clk) begin
        if (sclk_o && !sclk_prev) adc_data = si_o ? 12'd0 : adc_data + 12'd1;
        sclk_prev = sclk_o;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        pix_t e;
        if (pix_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_pixel: got data %0d, expected no pixel", pix_data);
            end else begin
                e = sb.pop_front();
                chk("pix_data", pix_data, e.d);
                chk("pix_sol", pix_sol, e.sol);
                chk("pix_eol", pix_eol, e.eol);
            end
            pix_seen++;
            if (pix_eol) eol_seen++;
        end
    end

    // SI pulse width and count
    always @(negedge clk) begin
        if (si_o) begin
            if (!si_prev) si_rises++;
            si_w++;
        end else if (si_w != 0) begin
            chk("si_width", si_w, CLK_DIV);
            si_w = 0;
        end
        si_prev = si_o;
    end

    // free-run timer instance: SI period
    always @(negedge clk) begin
        if (t_si && !t_si_prev) begin
            if (t_last >= 0) chk("tmr_si_interval", 32'(cyc - t_last), CLK_DIV * LP2);
            t_last = cyc;
            t_rises++;
        end
        t_si_prev = t_si;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        enable = 1'b1; m_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0; rst2 = 1'b0;

        // single line
        repeat ($urandom_range(5, 40)) @(posedge clk);
        issue_trig();
        wait_lines(1);
        check_idle("t1");

        // three trigs during one line: one extra line, two dropped
        issue_trig();
        wait_pix(100 + $urandom_range(0, 1500));
        repeat (3) begin
            issue_trig();
            repeat ($urandom_range(1, 200)) @(posedge clk);
        end
        wait_lines(2);
        check_idle("t2");

        // reset mid-line, then restart
        issue_trig();
        wait_pix(1000);
        @(posedge clk); #2 rst = 1'b1;
        sb.delete();
        m_busy = 0; m_pend = 0; m_lines = 0; m_ovf = 0; m_pushed = 0;
        @(negedge clk);
        check_zero("midline_rst");
        repeat ($urandom_range(2, 10)) @(posedge clk);
        #1 rst = 1'b0;
        issue_trig();
        wait_lines(1);
        check_idle("t4");

        // disable mid-line with a pending trigger
        issue_trig();
        wait_pix(200 + $urandom_range(0, 1500));
        enable = 1'b0; m_en = 0;
        repeat ($urandom_range(1, 100)) @(posedge clk);
        issue_trig();
        wait_lines(1);
        repeat (100 * CLK_DIV) @(negedge clk);
        chk("disabled_busy", busy, 0);
        chk("disabled_si_count", si_rises, m_starts);
        @(posedge clk); #1 enable = 1'b1; m_en = 1;
        if (m_pend) begin
            m_pend = 0; m_busy = 1; m_starts++;
        end
        wait_lines(1);
        check_idle("t5");

        chk("tmr_si_seen", 32'(t_rises >= 4), 1);
        chk("tmr_trig_ovf", t_ovf, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
